stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 10, count rate in Hz; DIV = CLK_HZ/TICK_HZ, integer and at least 2.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, number of consecutive stable cycles required to accept a button level.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on posedge clk.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports btn_run and btn_clear, input, 1 each, raw asynchronous push-buttons, high = pressed.
REQ-007 SHALL have port btn_lap, input, 1, raw lap button; present only when LAP_EN is defined.
REQ-008 SHALL have port cnt, output, 14, elapsed count 0..9999.
REQ-009 SHALL have port disp_cnt, output, 14, value for the FND controller.
REQ-010 SHALL have port running, output, 1, high while in state RUN.
REQ-011 SHALL have port tick, output, 1, one-cycle clock-enable pulse at TICK_HZ while running; no derived or gated clocks anywhere.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer and then a debouncer that flips its debounced level only after DEBOUNCE_CYCLES consecutive cycles of the synchronized value differing from it; any agreeing cycle restarts the count.
REQ-013 SHALL generate a one-cycle press pulse on each debounced 0->1 transition; a raw input held high from cycle 0 yields its press pulse in cycle DEBOUNCE_CYCLES+3; releases generate no pulse.
REQ-014 SHALL implement FSM states STOP, RUN, CLEAR; run press: STOP->RUN, RUN->STOP; clear press: STOP or RUN -> CLEAR; CLEAR -> STOP unconditionally after exactly one cycle.
REQ-015 SHALL give clear priority when run and clear presses coincide (next state CLEAR); presses arriving while in CLEAR are dropped.
REQ-016 SHALL advance the prescaler 0..DIV-1 only in RUN, assert tick in the cycle the prescaler equals DIV-1, and wrap it to 0 there.
REQ-017 SHALL hold the prescaler value in STOP, so a resume completes the interrupted period rather than starting a new one.
REQ-018 SHALL increment cnt by one in the cycle after tick and wrap 9999 -> 0; cnt never exceeds 9999.
REQ-019 SHALL zero cnt and the prescaler in CLEAR; tick and running are low in STOP and CLEAR.

Reset
REQ-020 SHALL, with rst high at a clk edge, set: state STOP; cnt, disp_cnt, prescaler and debounce counters 0; debounced levels and synchronizers 0; tick and running 0.
REQ-021 SHALL let rst override every other event, including a mid-debounce button or a tick due in the same cycle.

Configuration
REQ-022 SHALL, with macro STOPWATCH_LAP_EN defined, add btn_lap with the same debounce path; a lap press in RUN toggles lap_hold; while lap_hold, disp_cnt stays at the cnt value captured on the press, and cnt keeps counting.
REQ-023 SHALL, with STOPWATCH_LAP_EN defined, ignore lap presses in STOP and CLEAR, clear lap_hold in CLEAR and on rst, and keep lap_hold across RUN->STOP.
REQ-024 SHALL, without STOPWATCH_LAP_EN, omit btn_lap and lap logic; disp_cnt equals cnt every cycle.

Verification (CLK_HZ=100, TICK_HZ=10, DEBOUNCE_CYCLES=4)
REQ-025 SHALL check: btn_run high from cycle 0 -> press in cycle 7, running high in cycle 8; a 3-cycle glitch -> no press.
REQ-026 SHALL check: RUN for 100 cycles -> 10 tick pulses spaced 10 cycles apart, cnt=10.
REQ-027 SHALL check: stop at prescaler=6, wait 50 cycles, resume -> first tick 3 cycles after running rises; cnt unchanged while stopped.
REQ-028 SHALL check: cnt preset to 9999 via run, next tick -> cnt=0; simultaneous run and clear press -> CLEAR, then STOP with cnt=0.
REQ-029 SHALL check: rst asserted mid-RUN with cnt=42 -> all outputs 0 and state STOP on the next edge.
REQ-030 SHALL check (LAP_EN): lap at cnt=5, run 30 more cycles -> disp_cnt=5, cnt=8; lap again -> disp_cnt=8.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
// Push-button stopwatch core. Debounced run/clear buttons drive a
// STOP/RUN/CLEAR state machine. A prescaler derives a TICK_HZ clock-enable
// from clk, and a 0..9999 wrapping counter advances on each tick.
//
// Optional feature: define STOPWATCH_LAP_EN to add a lap button. A lap press
// in RUN freezes the displayed value while the count keeps running. A second
// lap press in RUN releases the freeze.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   btn_run    in   raw run/stop push-button (high = pressed)
//   btn_clear  in   raw clear push-button (high = pressed)
//   btn_lap    in   raw lap push-button (STOPWATCH_LAP_EN only)
//   cnt        out  elapsed count, 0..9999
//   disp_cnt   out  value for the display controller
//   running    out  high while in RUN
//   tick       out  one-cycle enable pulse at TICK_HZ while running
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned TICK_HZ         = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run,
  input  logic        btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic        btn_lap,
`endif
  output logic [13:0] cnt,
  output logic [13:0] disp_cnt,
  output logic        running,
  output logic        tick
);

  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned PS_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CNT_W   = 14;
  localparam int unsigned CNT_MAX = 9999;
  localparam int unsigned B_RUN   = 0;
  localparam int unsigned B_CLEAR = 1;
`ifdef STOPWATCH_LAP_EN
  localparam int unsigned B_LAP   = 2;
  localparam int unsigned NB      = 3;
`else
  localparam int unsigned NB      = 2;
`endif

  typedef enum logic [1:0] {
    S_STOP  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  logic [NB-1:0]   btn_raw;
  logic [NB-1:0]   sync1;
  logic [NB-1:0]   sync2;
  logic [NB-1:0]   db_lvl;
  logic [NB-1:0]   db_prev;
  logic [NB-1:0]   press;
  logic [DB_W-1:0] db_cnt [NB];

  state_t          state;
  state_t          state_nxt;
  logic [PS_W-1:0] presc;
  logic [PS_W-1:0] presc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] disp_nxt;
  logic             tick_nxt;
  logic             running_nxt;

`ifdef STOPWATCH_LAP_EN
  logic             lap_hold;
  logic             lap_hold_nxt;
  logic [CNT_W-1:0] lap_val;
  logic [CNT_W-1:0] lap_val_nxt;

  assign btn_raw = {btn_lap, btn_clear, btn_run};
`else
  assign btn_raw = {btn_clear, btn_run};
`endif

  // Synchronize, debounce and edge-detect every button. The press pulse is
  // registered, so a level held from cycle 0 yields its pulse in cycle
  // DEBOUNCE_CYCLES+3.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      db_lvl  <= '0;
      db_prev <= '0;
      press   <= '0;
      for (int i = 0; i < int'(NB); i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      db_prev <= db_lvl;
      press   <= db_lvl & ~db_prev;
      for (int i = 0; i < int'(NB); i++) begin
        if (sync2[i] != db_lvl[i]) begin
          if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_lvl[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          // any agreeing cycle restarts the stability window
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // State, prescaler, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_STOP;
      presc    <= '0;
      cnt      <= '0;
      disp_cnt <= '0;
      tick     <= 1'b0;
      running  <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_hold <= 1'b0;
      lap_val  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      cnt      <= cnt_nxt;
      disp_cnt <= disp_nxt;
      tick     <= tick_nxt;
      running  <= running_nxt;
`ifdef STOPWATCH_LAP_EN
      lap_hold <= lap_hold_nxt;
      lap_val  <= lap_val_nxt;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    cnt_nxt   = cnt;
`ifdef STOPWATCH_LAP_EN
    lap_hold_nxt = lap_hold;
    lap_val_nxt  = lap_val;
`endif

    unique case (state)
      S_STOP: begin
        // clear wins over a coincident run press
        if (press[B_CLEAR]) begin
          state_nxt = S_CLEAR;
        end else if (press[B_RUN]) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (press[B_CLEAR]) begin
          state_nxt = S_CLEAR;
        end else if (press[B_RUN]) begin
          state_nxt = S_STOP;
        end
      end
      S_CLEAR: begin
        state_nxt = S_STOP;
      end
      default: begin
        state_nxt = S_STOP;
      end
    endcase

    // Prescaler only moves in RUN; its value is kept across STOP so a
    // resume finishes the interrupted period.
    if (state == S_CLEAR) begin
      presc_nxt = '0;
      cnt_nxt   = '0;
    end else if (state == S_RUN) begin
      presc_nxt = (presc == PS_W'(DIV - 1)) ? '0 : presc + PS_W'(1);
    end

    // tick is only ever high in a RUN cycle, so it never collides with CLEAR
    if (tick) begin
      cnt_nxt = (cnt == CNT_W'(CNT_MAX)) ? '0 : cnt + CNT_W'(1);
    end

`ifdef STOPWATCH_LAP_EN
    if (state == S_CLEAR) begin
      lap_hold_nxt = 1'b0;
    end else if ((state == S_RUN) && press[B_LAP]) begin
      lap_hold_nxt = ~lap_hold;
      lap_val_nxt  = cnt;
    end
    disp_nxt = lap_hold_nxt ? lap_val_nxt : cnt_nxt;
`else
    disp_nxt = cnt_nxt;
`endif

    running_nxt = (state_nxt == S_RUN);
    tick_nxt    = (state_nxt == S_RUN) && (presc_nxt == PS_W'(DIV - 1));
  end

endmodule
